// File: rtl/os_pkg.sv
// Shared constants for the output-stationary drain block: FSM encoding and default array geometry.
package os_pkg;

    localparam int PSUM_BW_DEF = 16;
    localparam int COL_DEF     = 8;
    localparam int ROW_DEF     = 8;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

endpackage

// File: rtl/os_drain_if.sv
// Row-wide write port from the drain block into the downstream output FIFO.
interface os_drain_if
    import os_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int col     = COL_DEF
);
    logic                     ofifo_wr;
    logic [col*psum_bw-1:0]   ofifo_data;
    logic                     ofifo_full;

    modport master (output ofifo_wr, output ofifo_data, input ofifo_full);
    modport slave  (input ofifo_wr, input ofifo_data, output ofifo_full);
endinterface

// File: rtl/os_capture_bank.sv
// One array row of result storage: latches each tile's first valid result and tracks capture bits.
// With OS_DRAIN_ERR_EN defined, also reports repeat-valid (duplicate) events.
module os_capture_bank
    import os_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int col     = COL_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cap_en,
    input  logic                   clr,
    input  logic [col-1:0]         valid,
    input  logic [col*psum_bw-1:0] din,
    output logic [col*psum_bw-1:0] dout,
    output logic                   all_cap_next,
    output logic                   any_new
`ifdef OS_DRAIN_ERR_EN
    ,
    output logic                   dup
`endif
);
    logic [col-1:0] cap;
    logic [col-1:0] take;

    assign take         = valid & ~cap & {col{cap_en}};
    assign any_new      = |take;
    assign all_cap_next = &(cap | take);
`ifdef OS_DRAIN_ERR_EN
    assign dup          = cap_en && |(valid & cap);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap  <= '0;
            dout <= '0;
        end else begin
            cap <= clr ? '0 : (cap | take);
            // only the first valid per set is kept; later repeats are dropped
            for (int c = 0; c < col; c++) begin
                if (take[c]) dout[c*psum_bw +: psum_bw] <= din[c*psum_bw +: psum_bw];
            end
        end
    end
endmodule

// File: rtl/os_drain.sv
// Collects a full set of output-stationary tile results, then streams it row by row into the ofifo.
// Defining OS_DRAIN_ERR_EN adds the sticky overrun port for repeat/late tile_valid events.
//
// state    | meaning
// IDLE     | no tile captured in the current set
// CAPTURE  | some tiles captured, waiting for the rest
// DRAIN    | full set held, writing rows 0..row-1 to the ofifo
module os_drain
    import os_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int col     = COL_DEF,
    parameter int row     = ROW_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       toggle,
    input  logic [row*col-1:0]         tile_valid,
    input  logic [row*col*psum_bw-1:0] tile_out,
    os_drain_if.master                 ofifo,
    output logic                       drain_busy,
    output logic                       done
`ifdef OS_DRAIN_ERR_EN
    ,
    output logic                       overrun
`endif
);
    localparam int             PW       = (row > 1) ? $clog2(row) : 1;
    localparam logic [PW-1:0]  LAST_ROW = PW'(row - 1);

    logic [1:0]             state, state_nxt;
    logic [PW-1:0]          rd_ptr;
    logic [row-1:0]         all_next, any_new_r;
    logic [col*psum_bw-1:0] row_data [row];
    logic                   cap_en, clr, wr, last_wr;

    assign cap_en  = toggle && (state != ST_DRAIN);
    // toggle low holds the write strobe off in the same cycle, not only after the forced IDLE
    assign wr      = toggle && (state == ST_DRAIN) && !ofifo.ofifo_full;
    assign last_wr = wr && (rd_ptr == LAST_ROW);
    assign clr     = !toggle || last_wr;

    assign ofifo.ofifo_wr   = wr;
    assign ofifo.ofifo_data = row_data[rd_ptr];
    assign drain_busy       = (state == ST_DRAIN);

`ifdef OS_DRAIN_ERR_EN
    logic [row-1:0] dup_r;
`endif

    for (genvar r = 0; r < row; r++) begin : g_row
        os_capture_bank #(.psum_bw(psum_bw), .col(col)) u_bank (
            .clk          (clk),
            .reset        (reset),
            .cap_en       (cap_en),
            .clr          (clr),
            .valid        (tile_valid[r*col +: col]),
            .din          (tile_out[r*col*psum_bw +: col*psum_bw]),
            .dout         (row_data[r]),
            .all_cap_next (all_next[r]),
            .any_new      (any_new_r[r])
`ifdef OS_DRAIN_ERR_EN
            ,
            .dup          (dup_r[r])
`endif
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_CAPTURE: begin
                if (&all_next)       state_nxt = ST_DRAIN;
                else if (|any_new_r) state_nxt = ST_CAPTURE;
            end
            ST_DRAIN: if (last_wr) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (!toggle) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= ST_IDLE;
            rd_ptr <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= last_wr;
            if (clr)     rd_ptr <= '0;
            else if (wr) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef OS_DRAIN_ERR_EN
    logic ovr_evt;
    assign ovr_evt = toggle && ((state == ST_DRAIN) ? |tile_valid : |dup_r);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overrun <= 1'b0;
        else if (ovr_evt) overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_os_drain.sv
// Self-checking bench for os_drain: directed drain tables, corner sequences and a random run
// against a set-level reference model.
module tb_os_drain;
    localparam int PB = 16;
    localparam int COL = 8;
    localparam int ROW = 8;
    localparam int NT = ROW * COL;
    localparam int DW = COL * PB;

    logic clk = 1'b0;
    logic reset, toggle, drain_busy, done;
    logic [NT-1:0]    tile_valid;
    logic [NT*PB-1:0] tile_out;
`ifdef OS_DRAIN_ERR_EN
    logic overrun;
`endif

    os_drain_if #(.psum_bw(PB), .col(COL)) ofifo ();

    os_drain #(.psum_bw(PB), .col(COL), .row(ROW)) dut (
        .clk(clk), .reset(reset), .toggle(toggle), .tile_valid(tile_valid), .tile_out(tile_out),
        .ofifo(ofifo.master), .drain_busy(drain_busy), .done(done)
`ifdef OS_DRAIN_ERR_EN
        , .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, nwr = 0;

    // reference model: a set of captured tiles, drained as whole rows
    int m_bank [ROW][COL];
    bit m_cap  [ROW][COL];
    bit m_drain, m_done, m_ovr;
    int m_row;

    typedef struct { bit full; bit wr; bit busy; bit done; int row; } vec_t;
    vec_t va [10];
    vec_t vb [13];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int tval(input int base, input int r, input int c);
        return (base + r * 16 + c) & 16'hffff;
    endfunction

    function automatic logic [DW-1:0] exp_row(input int base, input int r);
        logic [DW-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PB +: PB] = tval(base, r, c);
        return d;
    endfunction

    function automatic logic [DW-1:0] model_row();
        logic [DW-1:0] d;
        for (int c = 0; c < COL; c++) d[c*PB +: PB] = m_bank[m_row][c];
        return d;
    endfunction

    task automatic m_reset();
        foreach (m_bank[r, c]) begin m_bank[r][c] = 0; m_cap[r][c] = 0; end
        m_drain = 0; m_done = 0; m_ovr = 0; m_row = 0;
    endtask

    task automatic m_clear_set();
        foreach (m_cap[r, c]) m_cap[r][c] = 0;
        m_row = 0;
    endtask

    task automatic m_update();
        int n;
        if (!toggle) begin
            m_drain = 0; m_done = 0; m_clear_set();
        end else if (m_drain) begin
            m_done = 0;
            if (|tile_valid) m_ovr = 1;
            if (!ofifo.ofifo_full) begin
                m_row++;
                if (m_row == ROW) begin m_drain = 0; m_clear_set(); m_done = 1; end
            end
        end else begin
            m_done = 0; n = 0;
            foreach (m_cap[r, c]) begin
                if (tile_valid[r*COL+c]) begin
                    if (m_cap[r][c]) m_ovr = 1;
                    else begin m_bank[r][c] = int'(tile_out[(r*COL+c)*PB +: PB]); m_cap[r][c] = 1; end
                end
                if (m_cap[r][c]) n++;
            end
            if (n == NT) m_drain = 1;
        end
    endtask

    task automatic check_model();
        chk("wr", ofifo.ofifo_wr, m_drain && toggle && !ofifo.ofifo_full);
        chk("busy", drain_busy, m_drain);
        chk("done", done, m_done);
        if (m_drain) chk("data", ofifo.ofifo_data, model_row());
`ifdef OS_DRAIN_ERR_EN
        chk("overrun", overrun, m_ovr);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_update();
        #1;
    endtask

    task automatic step();
        #1;
        check_model();
        if (ofifo.ofifo_wr) nwr++;
        tick();
    endtask

    task automatic set_all(input int base);
        tile_valid = '1;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) tile_out[(r*COL+c)*PB +: PB] = 16'(tval(base, r, c));
    endtask

    task automatic rand_out();
        for (int i = 0; i < NT * PB / 32; i++) tile_out[i*32 +: 32] = $urandom;
    endtask

    task automatic run_vec(input vec_t v, input int base, input string tag);
        tile_valid = '0;
        ofifo.ofifo_full = v.full;
        #1;
        chk({tag, "_wr"}, ofifo.ofifo_wr, v.wr);
        chk({tag, "_busy"}, drain_busy, v.busy);
        chk({tag, "_done"}, done, v.done);
        if (v.busy) chk({tag, "_data"}, ofifo.ofifo_data, exp_row(base, v.row));
        if (v.wr && v.row == 2) chk({tag, "_r2c3"}, ofifo.ofifo_data[3*PB +: PB], 16'h0023 + base[15:0]);
        check_model();
        if (ofifo.ofifo_wr) nwr++;
        tick();
    endtask

    task automatic drain_rand(input int maxc);
        int i;
        for (i = 0; i < maxc; i++) begin
            tile_valid = '0;
            ofifo.ofifo_full = ($urandom % 3) == 0;
            step();
            if (!m_drain && !m_done) break;
        end
        if (i == maxc) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) va[i] = '{0, 1, 1, 0, i};
        va[8] = '{0, 0, 0, 1, 0};
        va[9] = '{0, 0, 0, 0, 0};
        for (int i = 0; i < 4; i++) vb[i] = '{0, 1, 1, 0, i};
        for (int i = 4; i < 7; i++) vb[i] = '{1, 0, 1, 0, 4};
        for (int i = 7; i < 11; i++) vb[i] = '{0, 1, 1, 0, i - 3};
        vb[11] = '{0, 0, 0, 1, 0};
        vb[12] = '{0, 0, 0, 0, 0};

        reset = 0; toggle = 0; tile_valid = '0; tile_out = '0; ofifo.ofifo_full = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model();
        chk("rst_data", ofifo.ofifo_data, '0);
        reset = 1;
        tick();

        // all tiles in one cycle, unstalled drain
        toggle = 1;
        set_all(0);
        #1;
        chk("a_wr0", ofifo.ofifo_wr, 0);
        check_model();
        tick();
        foreach (va[i]) run_vec(va[i], 0, "a");

        // stall for 3 cycles on row 4
        set_all(16'h100);
        step();
        nwr = 0;
        foreach (vb[i]) run_vec(vb[i], 16'h100, "b");
        chk("b_writes", nwr, 8);

        // one tile per cycle in a scrambled order
        for (int k = 0; k < NT; k++) begin
            tile_valid = '0;
            tile_valid[(k * 37) % NT] = 1'b1;
            rand_out();
            #1;
            chk("c_nowr", ofifo.ofifo_wr, 0);
            step();
        end
        tile_valid = '0;
        ofifo.ofifo_full = 0;
        #1;
        chk("c_busy", drain_busy, 1);
        chk("c_wr", ofifo.ofifo_wr, 1);
        drain_rand(200);

        // repeat valid on tile (0,0): first value wins
        tile_valid = '0; tile_valid[0] = 1'b1; tile_out[PB-1:0] = 16'd5;
        step();
        tile_out[PB-1:0] = 16'd9;
        step();
        set_all(16'h200);
        tile_out[PB-1:0] = 16'd9;
        step();
        tile_valid = '0; ofifo.ofifo_full = 0;
        #1;
        chk("d_r0c0", ofifo.ofifo_data[PB-1:0], 16'd5);
        drain_rand(200);
`ifdef OS_DRAIN_ERR_EN
        chk("d_overrun", overrun, 1);
`endif

        // abort after 3 rows, then restart from row 0
        set_all(16'h300);
        step();
        tile_valid = '0; ofifo.ofifo_full = 0;
        repeat (3) step();
        toggle = 0;
        step();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("e_wr", ofifo.ofifo_wr, 0);
            chk("e_done", done, 0);
            check_model();
            tick();
        end
        toggle = 1;
        set_all(16'h400);
        step();
        tile_valid = '0; ofifo.ofifo_full = 0;
        #1;
        chk("e_row0", ofifo.ofifo_data, exp_row(16'h400, 0));
        drain_rand(200);

        // asynchronous reset mid-drain
        set_all(16'h500);
        step();
        tile_valid = '0; ofifo.ofifo_full = 0;
        repeat (2) step();
        #1;
        reset = 0;
        m_reset();
        #1;
        chk("f_wr", ofifo.ofifo_wr, 0);
        chk("f_busy", drain_busy, 0);
        chk("f_done", done, 0);
        tick();
        tick();
        reset = 1;
        set_all(16'h600);
        tile_valid[NT-1] = 1'b0;
        step();
        tile_valid = '0;
        #1;
        chk("f_nodrain", drain_busy, 0);
        tile_valid[NT-1] = 1'b1;
        step();
        tile_valid = '0;
        #1;
        chk("f_drain", drain_busy, 1);
        drain_rand(200);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            toggle = ($urandom % 60) != 0;
            rand_out();
            if (($urandom % 25) == 0) tile_valid = '1;
            else for (int b = 0; b < NT; b++) tile_valid[b] = ($urandom % 8) == 0;
            ofifo.ofifo_full = ($urandom % 4) == 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/os_drain.md
OS_DRAIN -- requirements
Module: os_drain

Interface
REQ-001 SHALL have parameter psum_bw, default 16, width of one tile result.
REQ-002 SHALL have parameter col, default 8, tiles per array row.
REQ-003 SHALL have parameter row, default 8, tiles per array column.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port toggle  input  1  mode: 0 = WS (block idle), 1 = OS (block active).
REQ-007 SHALL have port tile_valid  input  row*col  per-tile os_valid; bit index r*col+c.
REQ-008 SHALL have port tile_out  input  row*col*psum_bw  per-tile os_out; slice (r*col+c) holds tile (r,c).
REQ-009 SHALL have port ofifo_full  input  1  downstream ofifo cannot accept a write.
REQ-010 SHALL have port ofifo_wr  output  1  write strobe to ofifo.
REQ-011 SHALL have port ofifo_data  output  col*psum_bw  one array row; column 0 in LSBs.
REQ-012 SHALL have port drain_busy  output  1  high in DRAIN state.
REQ-013 SHALL have port done  output  1  one-cycle pulse after the last row is written.
REQ-014 SHALL have port overrun  output  1  sticky error flag; present only with OS_DRAIN_ERR_EN.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, DRAIN.
REQ-016 SHALL, in IDLE/CAPTURE with toggle=1, latch tile_out slice into bank[r][c] and set cap[r][c] on any cycle where tile_valid bit is 1 and cap[r][c] is 0.
REQ-017 SHALL move IDLE->CAPTURE on the first latched tile, and move to DRAIN on the edge where all cap bits become 1 (IDLE->DRAIN directly if all tiles are valid in one cycle).
REQ-018 SHALL keep the first captured value when a tile asserts valid again while its cap bit is set; the repeat counts as an overrun event.
REQ-019 SHALL drive ofifo_wr = (state==DRAIN) && !ofifo_full combinationally; ofifo_data = bank[rd_ptr].
REQ-020 SHALL increment rd_ptr on each cycle with ofifo_wr=1, rows emitted in order 0..row-1.
REQ-021 SHALL hold rd_ptr and ofifo_data while ofifo_full=1; no row is skipped or duplicated.
REQ-022 SHALL, on the write of row row-1, clear all cap bits, reset rd_ptr to 0, enter IDLE, and pulse done in the following cycle.
REQ-023 SHALL give first-write latency of one cycle: all-captured at edge N gives ofifo_wr=1 in cycle N+1 when not full.
REQ-024 SHALL ignore tile_valid during DRAIN (no capture); any asserted bit counts as an overrun event.
REQ-025 SHALL, when toggle=0, synchronously force IDLE, clear cap, rd_ptr and done, and hold ofifo_wr=0; a drain aborted mid-row does not pulse done.

Reset
REQ-026 SHALL on reset=0 asynchronously set state=IDLE, cap=0, rd_ptr=0, done=0, overrun=0, bank contents=0.
REQ-027 SHALL produce ofifo_wr=0, drain_busy=0, done=0, overrun=0 while reset=0, including reset asserted mid-drain.

Configuration
REQ-028 SHALL, with OS_DRAIN_ERR_EN defined, provide port overrun, set on any overrun event (REQ-018, REQ-024) and cleared only by reset.
REQ-029 SHALL, without OS_DRAIN_ERR_EN, omit port overrun and its logic; overrun events are silently dropped with identical data behaviour.

Structure
REQ-030 SHALL place FSM state encoding (2-bit IDLE=0, CAPTURE=1, DRAIN=2) and default parameter constants in shared package os_pkg.
REQ-031 SHALL instantiate one sub-module os_capture_bank per array row (col slices, cap bits, all-captured output); FSM and rd_ptr stay in os_drain.

Verification
REQ-032 SHALL cover: toggle=1, all 64 tile_valid high one cycle, tile (r,c) value r*16+c, ofifo_full=0 -> 8 consecutive writes starting next cycle, row 2 word column 3 = 0x0023, done pulse after row 7.
REQ-033 SHALL cover: tiles valid one per cycle over 64 cycles -> no write until cycle after the 64th; drain_busy rises then.
REQ-034 SHALL cover: ofifo_full held high for 3 cycles during row 4 -> ofifo_wr=0 those cycles, row 4 data stable, exactly 8 writes total.
REQ-035 SHALL cover: tile (0,0) valid with 5 then 9 before set complete -> row 0 column 0 emitted as 5; overrun=1 when OS_DRAIN_ERR_EN is defined.
REQ-036 SHALL cover: toggle driven to 0 after 3 rows drained -> ofifo_wr=0 next cycle, no done; new capture after toggle=1 starts at row 0.
REQ-037 SHALL cover: reset=0 asserted asynchronously mid-drain -> ofifo_wr, drain_busy, done go 0 immediately; after release state IDLE, cap all 0.
